// File: rtl/alu_result_writeback.sv
// Write-back stage for the SIMD ALU result bus: accepts one {H,L} result and writes
// L, then optionally H, to the vector register file; also flags per-lane overflow.
module alu_result_writeback #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned LANE_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       res_valid,
    output logic                       res_ready,
    input  logic [2*LANES*LANE_W-1:0]  res_data,
    input  logic [ADDR_W-1:0]          res_dst_lo,
    input  logic [ADDR_W-1:0]          res_dst_hi,
    input  logic                       res_wr_hi,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [LANES*LANE_W-1:0]    rf_wdata,
    input  logic                       rf_ready,
    output logic [LANES-1:0]           ovf_mask,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned DW = LANES * LANE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DW-1:0]       r_h;
    logic [ADDR_W-1:0]   r_dst_hi;
    logic                r_wr_hi;

    logic                r_rf_we;
    logic [ADDR_W-1:0]   r_rf_waddr;
    logic [DW-1:0]       r_rf_wdata;
    logic [LANES-1:0]    r_ovf_mask;
    logic                r_busy;
    logic                r_done;
    logic                r_res_ready;

    logic                w_accept;
    logic                w_we_nxt;
    logic [ADDR_W-1:0]   w_waddr_nxt;
    logic [DW-1:0]       w_wdata_nxt;
    logic                w_done_nxt;
    logic [LANES-1:0]    w_ovf;

    // A lane overflows when H is not the sign extension of the matching L lane.
    always_comb begin
        w_ovf = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w_ovf[i] = (res_data[DW + i*LANE_W +: LANE_W] !=
                        {LANE_W{res_data[i*LANE_W + LANE_W - 1]}});
        end
    end

    // Next-state and next-output logic; write outputs hold while the RF stalls.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_we_nxt    = r_rf_we;
        w_waddr_nxt = r_rf_waddr;
        w_wdata_nxt = r_rf_wdata;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                w_we_nxt = 1'b0;
                if (res_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = WR_LO;
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = res_dst_lo;
                    w_wdata_nxt = res_data[DW-1:0];
                end
            end
            WR_LO: begin
                if (rf_ready) begin
                    if (r_wr_hi) begin
                        w_state_nxt = WR_HI;
                        w_waddr_nxt = r_dst_hi;
                        w_wdata_nxt = r_h;
                    end else begin
                        w_state_nxt = IDLE;
                        w_we_nxt    = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            WR_HI: begin
                if (rf_ready) begin
                    w_state_nxt = IDLE;
                    w_we_nxt    = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_we_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_h         <= '0;
            r_dst_hi    <= '0;
            r_wr_hi     <= 1'b0;
            r_rf_we     <= 1'b0;
            r_rf_waddr  <= '0;
            r_rf_wdata  <= '0;
            r_ovf_mask  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_res_ready <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_rf_we     <= w_we_nxt;
            r_rf_waddr  <= w_waddr_nxt;
            r_rf_wdata  <= w_wdata_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_res_ready <= (w_state_nxt == IDLE);
            if (w_accept) begin
                r_h        <= res_data[2*DW-1:DW];
                r_dst_hi   <= res_dst_hi;
                r_wr_hi    <= res_wr_hi;
                r_ovf_mask <= w_ovf;
            end
        end
    end

    assign res_ready = r_res_ready;
    assign rf_we     = r_rf_we;
    assign rf_waddr  = r_rf_waddr;
    assign rf_wdata  = r_rf_wdata;
    assign ovf_mask  = r_ovf_mask;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_alu_result_writeback.sv
// Self-checking bench for alu_result_writeback: expected register-file writes are
// queued when a result is driven and compared as the DUT performs each write.
module tb_alu_result_writeback;

    localparam int unsigned LANES  = 16;
    localparam int unsigned LANE_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DW     = LANES * LANE_W;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 res_valid = 1'b0;
    logic                 res_ready;
    logic [2*DW-1:0]      res_data = '0;
    logic [ADDR_W-1:0]    res_dst_lo = '0;
    logic [ADDR_W-1:0]    res_dst_hi = '0;
    logic                 res_wr_hi = 1'b0;
    logic                 rf_we;
    logic [ADDR_W-1:0]    rf_waddr;
    logic [DW-1:0]        rf_wdata;
    logic                 rf_ready = 1'b1;
    logic [LANES-1:0]     ovf_mask;
    logic                 busy;
    logic                 done;

    alu_result_writeback #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_dst_lo(res_dst_lo), .res_dst_hi(res_dst_hi), .res_wr_hi(res_wr_hi),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
        .ovf_mask(ovf_mask), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DW-1:0]     data;
    } wr_t;

    wr_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every accepted RF write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && rf_we && rf_ready) begin
            wr_t e;
            check("sb_pending", DW'(sb_q.size() != 0), DW'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_waddr", DW'(rf_waddr), DW'(e.addr));
                check("sb_wdata", rf_wdata, e.data);
            end
        end
    end

    // Overflow when the 64-bit lane value {H,L} does not fit in a signed 32-bit value.
    function automatic logic [LANES-1:0] ovf_model(input logic [DW-1:0] l, input logic [DW-1:0] h);
        logic [LANES-1:0]   m;
        logic signed [63:0] v;
        logic signed [31:0] lo;
        m = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            lo   = l[i*LANE_W +: LANE_W];
            v    = {h[i*LANE_W +: LANE_W], l[i*LANE_W +: LANE_W]};
            m[i] = (v != 64'(lo));
        end
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] h,
                        input logic [ADDR_W-1:0] dlo, input logic [ADDR_W-1:0] dhi,
                        input logic whi, input logic hold_valid, output int acc_cyc);
        sb_q.push_back('{addr: dlo, data: l});
        if (whi) sb_q.push_back('{addr: dhi, data: h});
        res_data   = {h, l};
        res_dst_lo = dlo;
        res_dst_hi = dhi;
        res_wr_hi  = whi;
        res_valid  = 1'b1;
        acc_cyc    = -1;
        for (int k = 0; k < 50; k++) begin
            if (res_ready) begin
                step();
                acc_cyc = cyc;
                break;
            end
            step();
        end
        if (acc_cyc < 0) check("accept_timeout", DW'(res_ready), DW'(1));
        if (!hold_valid) res_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 30; k++) begin
            if (done) break;
            step();
        end
        check(tag, DW'(done), DW'(1));
        step();
    endtask

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int i = 0; i < int'(LANES); i++) v[i*LANE_W +: LANE_W] = $urandom;
        return v;
    endfunction

    // H lanes are either a sign extension of L or random, giving a mixed mask.
    function automatic logic [DW-1:0] rand_hi(input logic [DW-1:0] l);
        logic [DW-1:0] h;
        for (int i = 0; i < int'(LANES); i++) begin
            if ($urandom_range(1, 0) == 1)
                h[i*LANE_W +: LANE_W] = {LANE_W{l[i*LANE_W + LANE_W - 1]}};
            else
                h[i*LANE_W +: LANE_W] = $urandom;
        end
        return h;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] l, h, l4, h4, l5, h5;
        logic [DW-1:0] l5s[3];
        logic [DW-1:0] h5s[3];
        int a, acc[3];

        // Reset state
        #12;
        check("rst_we", DW'(rf_we), DW'(0));
        check("rst_waddr", DW'(rf_waddr), DW'(0));
        check("rst_wdata", rf_wdata, '0);
        check("rst_ovf", DW'(ovf_mask), DW'(0));
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_done", DW'(done), DW'(0));
        step();
        rst_n = 1'b1;
        step();
        check("rst_ready", DW'(res_ready), DW'(1));

        // 1: L lanes = i, H = 0, L then H on consecutive cycles
        rf_ready = 1'b1;
        for (int i = 0; i < int'(LANES); i++) l[i*LANE_W +: LANE_W] = LANE_W'(i);
        h = '0;
        send(l, h, 5'd3, 5'd4, 1'b1, 1'b0, a);
        check("t1_we_lo", DW'(rf_we), DW'(1));
        check("t1_addr_lo", DW'(rf_waddr), DW'(3));
        check("t1_busy", DW'(busy), DW'(1));
        check("t1_ready_lo", DW'(res_ready), DW'(0));
        check("t1_ovf", DW'(ovf_mask), DW'(16'h0000));
        step();
        check("t1_addr_hi", DW'(rf_waddr), DW'(4));
        check("t1_done_early", DW'(done), DW'(0));
        step();
        check("t1_done", DW'(done), DW'(1));
        check("t1_we_idle", DW'(rf_we), DW'(0));
        check("t1_ready_idle", DW'(res_ready), DW'(1));
        check("t1_busy_idle", DW'(busy), DW'(0));
        step();
        check("t1_done_pulse", DW'(done), DW'(0));

        // 2: lane 5 add overflow, lane 0 all-ones H/L is consistent
        for (int i = 0; i < int'(LANES); i++) l[i*LANE_W +: LANE_W] = LANE_W'(i + 1);
        h = '0;
        l[5*LANE_W +: LANE_W] = 32'h8000_0000;
        l[0 +: LANE_W]        = 32'hFFFF_FFFF;
        h[0 +: LANE_W]        = 32'hFFFF_FFFF;
        send(l, h, 5'd1, 5'd2, 1'b1, 1'b0, a);
        check("t2_ovf", DW'(ovf_mask), DW'(16'h0020));
        wait_done("t2_done");
        check("t2_ovf_hold", DW'(ovf_mask), DW'(16'h0020));

        // 3: wr_hi = 0 gives a single write and an earlier done
        l = rand_vec();
        h = rand_hi(l);
        send(l, h, 5'd7, 5'd9, 1'b0, 1'b0, a);
        check("t3_we", DW'(rf_we), DW'(1));
        check("t3_addr", DW'(rf_waddr), DW'(7));
        check("t3_ovf", DW'(ovf_mask), DW'(ovf_model(l, h)));
        step();
        check("t3_done", DW'(done), DW'(1));
        check("t3_we_off", DW'(rf_we), DW'(0));
        step();
        check("t3_we_still_off", DW'(rf_we), DW'(0));
        check("t3_addr_hold", DW'(rf_waddr), DW'(7));

        // 4: rf_ready low for 4 cycles in WR_LO
        l4 = rand_vec();
        h4 = rand_hi(l4);
        rf_ready = 1'b0;
        send(l4, h4, 5'd12, 5'd13, 1'b1, 1'b0, a);
        for (int i = 0; i < 5; i++) begin
            check("t4_we_stall", DW'(rf_we), DW'(1));
            check("t4_addr_stall", DW'(rf_waddr), DW'(12));
            check("t4_data_stall", rf_wdata, l4);
            check("t4_ready_stall", DW'(res_ready), DW'(0));
            if (i == 4) rf_ready = 1'b1;
            step();
        end
        check("t4_addr_hi", DW'(rf_waddr), DW'(13));
        check("t4_ready_hi", DW'(res_ready), DW'(0));
        wait_done("t4_done");

        // 5: res_valid held high across three results
        for (int r = 0; r < 3; r++) begin
            l5s[r] = rand_vec();
            h5s[r] = rand_hi(l5s[r]);
        end
        for (int r = 0; r < 3; r++) begin
            send(l5s[r], h5s[r], 5'(16 + 2*r), 5'(17 + 2*r), 1'b1, 1'b1, acc[r]);
            check("t5_ovf", DW'(ovf_mask), DW'(ovf_model(l5s[r], h5s[r])));
        end
        res_valid = 1'b0;
        check("t5_gap01", DW'(acc[1] - acc[0]), DW'(3));
        check("t5_gap12", DW'(acc[2] - acc[1]), DW'(3));
        wait_done("t5_done");

        // 6: reset asserted during WR_HI
        l5 = rand_vec();
        h5 = rand_hi(l5);
        send(l5, h5, 5'd10, 5'd11, 1'b1, 1'b0, a);
        step();
        check("t6_addr_hi", DW'(rf_waddr), DW'(11));
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_we", DW'(rf_we), DW'(0));
        check("t6_waddr", DW'(rf_waddr), DW'(0));
        check("t6_wdata", rf_wdata, '0);
        check("t6_busy", DW'(busy), DW'(0));
        check("t6_ovf", DW'(ovf_mask), DW'(0));
        check("t6_abandoned", DW'(sb_q.size()), DW'(1));
        if (sb_q.size() != 0) void'(sb_q.pop_front());
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t6_no_done", DW'(done), DW'(0));
            step();
        end
        l = rand_vec();
        h = rand_hi(l);
        send(l, h, 5'd20, 5'd20, 1'b1, 1'b0, a);
        check("t6_resume_ovf", DW'(ovf_mask), DW'(ovf_model(l, h)));
        wait_done("t6_resume_done");

        check("sb_empty", DW'(sb_q.size()), DW'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
